// File: rtl/icache_refill.sv
// Instruction-cache miss refill: fetches a 16-bit parcel as two bytes from the shared
// byte-wide RAM port and hands it to the cache as a single registered write pulse.
module icache_refill #(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             miss_valid,
  input  logic [31:0]      miss_addr,
  input  logic             flush,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [31:0]      mem_a,
  input  logic [7:0]       mem_din,
  output logic             fill_we,
  output logic [31:0]      fill_data,
  output logic [31:0]      fill_addr,
  output logic             busy,
  output logic [CNT_W-1:0] fill_count
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WAIT_HI, WRITE} state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_addr;
  logic [7:0]         r_lo, r_hi;
  logic               r_lo_ok;
  logic               r_fill_we;
  logic [31:0]        r_fill_data, r_fill_addr;
  logic [CNT_W-1:0]   r_fill_count;
  logic [31:0]        w_miss_a;
  logic               w_accept, w_abort, w_do_write;

  assign w_miss_a = {miss_addr[31:1], 1'b0};
  assign w_accept = (r_state == IDLE) && miss_valid && !flush;
  assign w_abort  = (r_state != IDLE) && flush;
  // The cache indexes its write by its current miss address, so a fill whose target
  // no longer matches that miss must be dropped.
  assign w_do_write = (r_state == WRITE) && !flush && miss_valid && (w_miss_a == r_addr);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_state <= IDLE;
    else if (rdy_in) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RD_LO;
      RD_LO:   if (mem_gnt)  w_next = RD_HI;
      RD_HI:   if (mem_gnt)  w_next = WAIT_HI;
      WAIT_HI: w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_comb begin
    mem_req = rdy_in && !flush && ((r_state == RD_LO) || (r_state == RD_HI));
    mem_a   = (r_state == RD_HI) ? r_addr + 32'd1 : r_addr;
    busy    = (r_state != IDLE);
    fill_we = r_fill_we && rdy_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_addr       <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_lo_ok      <= 1'b0;
      r_fill_we    <= 1'b0;
      r_fill_data  <= '0;
      r_fill_addr  <= '0;
      r_fill_count <= '0;
    end else if (rdy_in) begin
      r_fill_we <= w_do_write;
      if (w_accept) begin
        r_addr      <= w_miss_a;
        r_fill_addr <= w_miss_a;
      end
      // mem_din holds the low byte only in the first RD_HI cycle; later stall cycles do not.
      if ((r_state == RD_HI) && !r_lo_ok) begin
        r_lo    <= mem_din;
        r_lo_ok <= 1'b1;
      end
      if (r_state == WAIT_HI) r_hi <= mem_din;
      if (r_state == WRITE)   r_lo_ok <= 1'b0;
      if (w_do_write) begin
        r_fill_data  <= {16'b0, r_hi, r_lo};
        r_fill_count <= r_fill_count + CNT_W'(1);
      end
      if (w_abort) r_lo_ok <= 1'b0;
    end
  end

  assign fill_data  = r_fill_data;
  assign fill_addr  = r_fill_addr;
  assign fill_count = r_fill_count;

endmodule
